// File: rtl/knn_pkg.sv
// Shared constants and types for the k-NN classification back end.
// Neighbour count, field widths, the sorter's empty-slot marker and the
// voter FSM state encoding.
package knn_pkg;
  localparam int K           = 5;
  localparam int DIST_W      = 18;
  localparam int CLASS_W     = 2;
  localparam int NUM_CLASSES = 4;
  localparam int ENTRY_W     = DIST_W + CLASS_W;

  // Vote counts and first-seen ranks both have to hold the value K.
  localparam int CNT_W = $clog2(K + 1);
  localparam int IDX_W = $clog2(K);

  // The sorter fills unused slots with an all-ones distance.
  localparam logic [DIST_W-1:0] MAX_DIST = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/knn_vote_resolve.sv
// Combinational winner selection over all classes.
// Ports:
//   cnt_flat   in   per-class vote counts, class i at [i*CNT_W +: CNT_W]
//   rank_flat  in   per-class first rank seen (K = never seen), same packing
//   win_class  out  class with the most votes, ties to the smallest rank
//   win_cnt    out  vote count of win_class
//   none       out  no class received any vote
module knn_vote_resolve
  import knn_pkg::*;
(
  input  logic [NUM_CLASSES*CNT_W-1:0] cnt_flat,
  input  logic [NUM_CLASSES*CNT_W-1:0] rank_flat,
  output logic [CLASS_W-1:0]           win_class,
  output logic [CNT_W-1:0]             win_cnt,
  output logic                         none
);
  logic [CNT_W-1:0] c;
  logic [CNT_W-1:0] r;
  logic [CNT_W-1:0] best_rank;

  // Seen classes have distinct ranks, so the rank compare fully orders ties.
  // With no votes at all every rank is K and class 0 is kept.
  always_comb begin
    c         = '0;
    r         = '0;
    win_class = '0;
    win_cnt   = cnt_flat[CNT_W-1:0];
    best_rank = rank_flat[CNT_W-1:0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      c = cnt_flat[i*CNT_W +: CNT_W];
      r = rank_flat[i*CNT_W +: CNT_W];
      if ((c > win_cnt) || ((c == win_cnt) && (r < best_rank))) begin
        win_class = CLASS_W'(i);
        win_cnt   = c;
        best_rank = r;
      end
    end
    none = (win_cnt == '0);
  end
endmodule

// File: rtl/knn_majority_voter.sv
// Majority vote over the K nearest neighbours delivered by the top-K sorter.
// A start pulse snapshots the packed list, entries are scanned one per clock,
// and the winning class is presented with a one-cycle result_valid.
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a vote (accepted in IDLE only)
//   sorted_list   in   K entries of {dist, class}, rank 1 at the LSBs
//   busy          out  vote in progress
//   result_valid  out  one-cycle strobe, result outputs are valid
//   pred_class    out  winning class, held until the next accepted start
//   win_votes     out  votes received by the winner
//   no_valid      out  every entry was an empty slot
module knn_majority_voter
  import knn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [K*ENTRY_W-1:0] sorted_list,
  output logic                 busy,
  output logic                 result_valid,
  output logic [CLASS_W-1:0]   pred_class,
  output logic [CNT_W-1:0]     win_votes,
  output logic                 no_valid
);
  state_t               state;
  logic [K*ENTRY_W-1:0] shadow;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt        [NUM_CLASSES];
  logic [CNT_W-1:0]     first_rank [NUM_CLASSES];

  logic [NUM_CLASSES*CNT_W-1:0] cnt_flat;
  logic [NUM_CLASSES*CNT_W-1:0] rank_flat;
  logic [CLASS_W-1:0]           res_class;
  logic [CNT_W-1:0]             res_cnt;
  logic                         res_none;

  // The shadow shifts down one entry per scan cycle, so the entry under
  // examination is always in the low bits.
  logic [DIST_W-1:0]  cur_dist;
  logic [CLASS_W-1:0] cur_cls;
  assign cur_dist = shadow[ENTRY_W-1:CLASS_W];
  assign cur_cls  = shadow[CLASS_W-1:0];

  always_comb begin
    cnt_flat  = '0;
    rank_flat = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_flat[i*CNT_W +: CNT_W]  = cnt[i];
      rank_flat[i*CNT_W +: CNT_W] = first_rank[i];
    end
  end

  knn_vote_resolve u_resolve (
    .cnt_flat  (cnt_flat),
    .rank_flat (rank_flat),
    .win_class (res_class),
    .win_cnt   (res_cnt),
    .none      (res_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      pred_class   <= '0;
      win_votes    <= '0;
      no_valid     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt[i]        <= '0;
        first_rank[i] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= sorted_list;
            idx    <= '0;
            busy   <= 1'b1;
            for (int i = 0; i < NUM_CLASSES; i++) begin
              cnt[i]        <= '0;
              first_rank[i] <= CNT_W'(K);
            end
            state <= SCAN;
          end
        end
        SCAN: begin
          if (cur_dist != MAX_DIST) begin
            cnt[cur_cls] <= cnt[cur_cls] + 1'b1;
            if (first_rank[cur_cls] == CNT_W'(K)) begin
              first_rank[cur_cls] <= CNT_W'(idx);
            end
          end
          shadow <= shadow >> ENTRY_W;
          idx    <= idx + 1'b1;
          if (idx == IDX_W'(K - 1)) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          pred_class   <= res_class;
          win_votes    <= res_cnt;
          no_valid     <= res_none;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_knn_majority_voter.sv
module tb_knn_majority_voter;
  import knn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [K*ENTRY_W-1:0] sorted_list = '0;
  logic                 busy;
  logic                 result_valid;
  logic [CLASS_W-1:0]   pred_class;
  logic [CNT_W-1:0]     win_votes;
  logic                 no_valid;

  knn_majority_voter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sorted_list  (sorted_list),
    .busy         (busy),
    .result_valid (result_valid),
    .pred_class   (pred_class),
    .win_votes    (win_votes),
    .no_valid     (no_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic [CNT_W-1:0]   votes;
    logic               nv;
    int                 t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  localparam logic [DIST_W-1:0] E = '1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endfunction

  function automatic logic [K*ENTRY_W-1:0] mk(
    input logic [DIST_W-1:0] d0, input logic [CLASS_W-1:0] c0,
    input logic [DIST_W-1:0] d1, input logic [CLASS_W-1:0] c1,
    input logic [DIST_W-1:0] d2, input logic [CLASS_W-1:0] c2,
    input logic [DIST_W-1:0] d3, input logic [CLASS_W-1:0] c3,
    input logic [DIST_W-1:0] d4, input logic [CLASS_W-1:0] c4);
    return {d4, c4, d3, c3, d2, c2, d1, c1, d0, c0};
  endfunction

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency", cyc + 1 - e.t0, K + 2);
        check("pred_class", int'(pred_class), int'(e.cls));
        check("win_votes", int'(win_votes), int'(e.votes));
        check("no_valid", int'(no_valid), int'(e.nv));
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < 40);
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Drive one start; returns with the start edge just passed (#1 after it).
  task automatic issue(input logic [K*ENTRY_W-1:0] lst, input logic [CLASS_W-1:0] cls,
                       input logic [CNT_W-1:0] votes, input logic nv, input bit push);
    exp_t e;
    sorted_list = lst;
    start       = 1'b1;
    e.cls = cls; e.votes = votes; e.nv = nv; e.t0 = cyc + 1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  logic [K*ENTRY_W-1:0] l1, l2, l3, l4, l5, l7;

  initial begin
    l1 = mk(18'd10, 2'd2, 18'd20, 2'd2, 18'd30, 2'd1, 18'd40, 2'd3, 18'd50, 2'd2);
    l2 = mk(18'd10, 2'd1, 18'd20, 2'd3, 18'd30, 2'd3, 18'd40, 2'd1, 18'd50, 2'd0);
    l3 = mk(E, 2'd1, E, 2'd2, E, 2'd3, E, 2'd1, E, 2'd2);
    l4 = mk(18'd5, 2'd3, 18'd9, 2'd1, E, 2'd0, E, 2'd0, E, 2'd0);
    l5 = mk(18'd1, 2'd3, 18'd2, 2'd0, 18'd3, 2'd0, 18'd4, 2'd1, 18'd5, 2'd0);
    l7 = mk(E, 2'd0, 18'd1, 2'd1, 18'd2, 2'd2, 18'd3, 2'd3, 18'd4, 2'd3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_pred_class", int'(pred_class), 0);
    check("rst_win_votes", int'(win_votes), 0);
    check("rst_no_valid", int'(no_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. clear majority: class 2 with 3 votes
    issue(l1, 2'd2, 3'd3, 1'b0, 1'b1);
    wait_drain();
    // Outputs held after the strobe
    repeat (3) @(posedge clk);
    #1;
    check("hold_pred_class", int'(pred_class), 2);
    check("hold_win_votes", int'(win_votes), 3);

    // 2. tie 1 vs 3 at two votes each, class 1 seen first
    issue(l2, 2'd1, 3'd2, 1'b0, 1'b1);
    wait_drain();

    // 3. all empty slots
    issue(l3, 2'd0, 3'd0, 1'b1, 1'b1);
    wait_drain();

    // 4. partial list: tie 3 vs 1 at one vote, class 3 nearer
    issue(l4, 2'd3, 3'd1, 1'b0, 1'b1);
    wait_drain();

    // 7. empty rank-1 slot skipped, class 3 wins with 2
    issue(l7, 2'd3, 3'd2, 1'b0, 1'b1);
    wait_drain();

    // 5. list changed at T0+1, extra start at T0+2: both ignored
    issue(l5, 2'd0, 3'd3, 1'b0, 1'b1);
    sorted_list = l1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_midscan", int'(busy), 1);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    check("no_second_result", exp_q.size(), 0);
    check("hold_after_ignored_start", int'(pred_class), 0);

    // 6. reset during scan aborts without a result
    issue(l1, 2'd2, 3'd3, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_result_valid", int'(result_valid), 0);
    check("async_rst_pred_class", int'(pred_class), 0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle_busy", int'(busy), 0);
    issue(l2, 2'd1, 3'd2, 1'b0, 1'b1);
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
